spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave with a one-byte transmit buffer and a single
// receive holding register; all pins are resynchronized into clk.
module spi_slave #(
  parameter logic [7:0] DEFAULT_TX = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       underrun
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0] sck_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] buf_data;
  logic       buf_full;
  logic       reload_q;

  logic sck_rise;
  logic sck_fall;
  logic ss_fall;
  logic ss_rise;
  logic load;
  logic shift_rx;
  logic shift_tx;
  logic done;
  logic abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ss_q   <= {ss_q[1:0], ss_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Deselect takes priority over any sck edge seen in the same cycle.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_rx = 1'b0;
    shift_tx = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else begin
          if (sck_rise) begin
            shift_rx = 1'b1;
            done     = (bit_cnt == 3'd7);
          end
          if (sck_fall) begin
            if (reload_q) begin
              load = 1'b1;
            end else begin
              shift_tx = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= 8'h00;
      reload_q <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (abort) begin
        bit_cnt  <= 3'd0;
        reload_q <= 1'b0;
      end
      if (shift_rx) begin
        rx_shift <= {rx_shift[6:0], mosi_q[1]};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (done) begin
        reload_q <= 1'b1;
      end
      if (load) begin
        reload_q <= 1'b0;
        tx_shift <= buf_full ? buf_data : DEFAULT_TX;
        underrun <= ~buf_full;
      end else if (shift_tx) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // A load sees the old buffer; a same-cycle write refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= 8'h00;
    end else begin
      if (load && buf_full) begin
        buf_full <= 1'b0;
      end
      if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        rx_data  <= {rx_shift[6:0], mosi_q[1]};
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & tx_shift[7];
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged mode-0 master at clk/8
// plus a per-cycle monitor of select, idle-line and pulse behaviour.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       sck;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       overrun;
  logic       underrun;

  spi_slave dut (
    .clk(clk),
    .rst(rst),
    .sck(sck),
    .ss_n(ss_n),
    .mosi(mosi),
    .miso(miso),
    .miso_oe(miso_oe),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .busy(busy),
    .overrun(overrun),
    .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mtx [4];
  logic [7:0] mrx [4];
  bit         ready_hit = 0;

  int ovr_cnt = 0;
  int und_cnt = 0;
  int rxv_rises = 0;
  int last_lat = 0;
  int lo_cnt = 0;
  int hi_cnt = 0;
  int ecnt = 0;
  logic prev_sck = 0;
  logic prev_rxv = 0;
  logic prev_ovr = 0;
  logic prev_und = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {17'd0, miso, miso_oe, busy, tx_ready, rx_valid,
               rx_data, overrun, underrun},
        {17'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
  endtask

  // Select model: 3 clk samples of a stable pin decide busy.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      lo_cnt = 0;
      hi_cnt = 0;
      chk("rst_busy", {busy, miso_oe, miso}, 3'b000);
    end else begin
      if (ss_n) begin
        hi_cnt++;
        lo_cnt = 0;
      end else begin
        lo_cnt++;
        hi_cnt = 0;
      end
      if (lo_cnt >= 3) begin
        chk("sel_busy", {busy, miso_oe}, 2'b11);
      end else if (hi_cnt >= 3) begin
        chk("idle_lines", {busy, miso_oe, miso}, 3'b000);
      end
    end
    if (sck && !prev_sck) ecnt = 1;
    else ecnt++;
    if (rx_valid && !prev_rxv) begin
      rxv_rises++;
      last_lat = ecnt;
    end
    chk("ovr_1cyc", {31'd0, overrun & prev_ovr}, 0);
    chk("und_1cyc", {31'd0, underrun & prev_und}, 0);
    ovr_cnt += int'(overrun);
    und_cnt += int'(underrun);
    prev_sck = sck;
    prev_rxv = rx_valid;
    prev_ovr = overrun;
    prev_und = underrun;
  end

  task automatic write_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("consume", {31'd0, rx_valid}, 0);
  endtask

  // cut: stop after that many rises; hold keeps sck high and ss low.
  task automatic spi_xfer(input int nb, input int cut, input bit hold);
    int cnt;
    bit stop;
    cnt  = 0;
    stop = 0;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nb && !stop; i++) begin
      for (int j = 7; j >= 0 && !stop; j--) begin
        mosi = mtx[i][j];
        repeat (4) @(negedge clk);
        sck = 1'b1;
        mrx[i][j] = miso;
        cnt++;
        if (ready_hit && i == nb - 1 && j == 0) begin
          repeat (2) @(negedge clk);
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
          @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
        if (cnt == cut && hold) begin
          stop = 1;
        end else begin
          sck = 1'b0;
          if (cnt == cut || (i == nb - 1 && j == 0)) begin
            ss_n = 1'b1;
            stop = 1;
          end
        end
      end
    end
    if (!hold) repeat (8) @(negedge clk);
  endtask

  int u0;
  int o0;
  int r0;

  initial begin
    rst      = 1'b1;
    sck      = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_vals");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Buffered A5 out, 3C in.
    chk("tx_ready0", {31'd0, tx_ready}, 1);
    write_tx(8'hA5);
    chk("tx_full", {31'd0, tx_ready}, 0);
    u0 = und_cnt; o0 = ovr_cnt; r0 = rxv_rises;
    mtx[0] = 8'h3C;
    spi_xfer(1, 0, 0);
    chk("a5_miso", {24'd0, mrx[0]}, 32'hA5);
    chk("3c_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h3C});
    chk("rx_lat", last_lat, 3);
    chk("a5_rises", rxv_rises - r0, 1);
    chk("a5_pulses", {und_cnt - u0, ovr_cnt - o0}, 0);
    chk("tx_empty", {31'd0, tx_ready}, 1);
    consume();

    // Empty buffer: default byte and one underrun.
    u0 = und_cnt;
    mtx[0] = 8'h5A;
    spi_xfer(1, 0, 0);
    chk("dflt_miso", {24'd0, mrx[0]}, 32'h00);
    chk("dflt_und", und_cnt - u0, 1);
    chk("5a_rx", {24'd0, rx_data}, 32'h5A);
    consume();

    // Back-to-back bytes with consumer stalled.
    write_tx(8'h11);
    u0 = und_cnt; o0 = ovr_cnt;
    mtx[0] = 8'h01;
    mtx[1] = 8'h02;
    spi_xfer(2, 0, 0);
    chk("b2b_miso0", {24'd0, mrx[0]}, 32'h11);
    chk("b2b_miso1", {24'd0, mrx[1]}, 32'h00);
    chk("b2b_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h02});
    chk("b2b_ovr", ovr_cnt - o0, 1);
    chk("b2b_und", und_cnt - u0, 1);
    consume();

    // Deselect after 5 bits; buffered byte written mid-frame survives.
    write_tx(8'hC3);
    r0 = rxv_rises; u0 = und_cnt;
    mtx[0] = 8'hFF;
    fork
      spi_xfer(1, 5, 0);
      begin
        repeat (20) @(negedge clk);
        write_tx(8'h96);
      end
    join
    chk("abort_bits", {27'd0, mrx[0][7:3]}, 32'h18);
    chk("abort_rx", {31'd0, rx_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_buf", {31'd0, tx_ready}, 0);
    mtx[0] = 8'h81;
    spi_xfer(1, 0, 0);
    chk("after_miso", {24'd0, mrx[0]}, 32'h96);
    chk("after_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h81});
    chk("after_rises", rxv_rises - r0, 1);
    chk("after_und", und_cnt - u0, 0);
    consume();

    // Held tx_valid while full, then completion racing rx_ready.
    write_tx(8'h3E);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_full", {31'd0, tx_ready}, 0);
    tx_valid = 1'b0;
    mtx[0] = 8'h12;
    spi_xfer(1, 0, 0);
    chk("hold_miso", {24'd0, mrx[0]}, 32'h3E);
    chk("hold_rx", {24'd0, rx_data}, 32'h12);
    o0 = ovr_cnt;
    ready_hit = 1;
    mtx[0] = 8'h34;
    spi_xfer(1, 0, 0);
    ready_hit = 0;
    chk("race_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h34});
    chk("race_ovr", ovr_cnt - o0, 0);
    consume();

    // Reset in the middle of a byte.
    write_tx(8'h5C);
    mtx[0] = 8'hF0;
    spi_xfer(1, 4, 1);
    chk("pre_rst_bits", {28'd0, mrx[0][7:4]}, 32'h5);
    write_tx(8'h6D);
    chk("pre_rst_buf", {31'd0, tx_ready}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    ss_n = 1'b1;
    sck  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset("post_rst");
    u0 = und_cnt;
    mtx[0] = 8'h99;
    spi_xfer(1, 0, 0);
    chk("rst_miso", {24'd0, mrx[0]}, 32'h00);
    chk("rst_und", und_cnt - u0, 1);
    chk("rst_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h99});
    consume();

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
